// File: rtl/ara_pkg.sv
// Shared vector-unit types: instruction IDs, element width and mask-router queue depth.
package ara_pkg;

    localparam int unsigned NrVInsn = 8;
    typedef logic [$clog2(NrVInsn)-1:0] vid_t;

    localparam int unsigned ELEN = 64;
    typedef logic [ELEN-1:0] elen_t;

    localparam int unsigned MaskRouterQueueDepth = 2;

endpackage

// File: rtl/vfu_mask_router_pkg.sv
// Mask-router local types: routing decision record and the tag-match resolver.
package vfu_mask_router_pkg;

    localparam int unsigned MaxFUs = 8;

    typedef struct packed {
        logic       hit;
        logic       multi;
        logic [2:0] idx;
    } route_t;

    // Lowest matching FU wins; multi flags more than one match.
    function automatic route_t route_lookup(logic [MaxFUs-1:0] match);
        route_t r;
        r = '0;
        for (int i = int'(MaxFUs) - 1; i >= 0; i--) begin
            if (match[i]) r.idx = 3'(i);
        end
        r.hit   = |match;
        r.multi = (match & (match - 8'd1)) != '0;
        return r;
    endfunction

endpackage

// File: rtl/vfu_mask_router_if.sv
// Mask-beat and per-FU delivery bundle between the mask unit, the router and the FUs.
interface vfu_mask_router_if #(
    parameter int unsigned NrFUs     = 2,
    parameter int unsigned DataWidth = $bits(ara_pkg::elen_t)
);
    localparam int unsigned StrbW = DataWidth / 8;

    logic [StrbW-1:0]              mask_i;
    ara_pkg::vid_t                 mask_vid_i;
    logic                          mask_valid_i;
    logic                          mask_ready_o;
    ara_pkg::vid_t [NrFUs-1:0]     fu_vid_i;
    logic [NrFUs-1:0]              fu_vid_valid_i;
    logic [NrFUs-1:0][StrbW-1:0]   fu_mask_o;
    logic [NrFUs-1:0]              fu_mask_valid_o;
    logic [NrFUs-1:0]              fu_mask_ready_i;
    logic [NrFUs-1:0]              fu_flush_i;
    logic                          conflict_o;

    modport master (
        output mask_i, mask_vid_i, mask_valid_i, fu_vid_i, fu_vid_valid_i,
               fu_mask_ready_i, fu_flush_i,
        input  mask_ready_o, fu_mask_o, fu_mask_valid_o, conflict_o
    );

    modport slave (
        input  mask_i, mask_vid_i, mask_valid_i, fu_vid_i, fu_vid_valid_i,
               fu_mask_ready_i, fu_flush_i,
        output mask_ready_o, fu_mask_o, fu_mask_valid_o, conflict_o
    );

endinterface

// File: rtl/vfu_mask_queue.sv
// Single per-FU mask FIFO with flush; ARA_MASK_ROUTER_BYPASS_EN adds an empty-queue bypass.
module vfu_mask_queue #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    input  logic             ready_i
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    logic [Width-1:0] mem_q [Depth];
    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t cnt_q, cnt_d;
    logic empty, bypass, store, pop;

    function automatic ptr_t ptr_inc(ptr_t p);
        if (p == ptr_t'(Depth - 1)) return '0;
        return p + ptr_t'(1);
    endfunction

    assign empty  = (cnt_q == '0);
    assign full_o = (cnt_q == cnt_t'(Depth));

`ifdef ARA_MASK_ROUTER_BYPASS_EN
    assign bypass = push_i & empty & ready_i & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    // A beat pushed during flush is accepted upstream but never stored.
    assign store = push_i & ~flush_i & ~bypass;
    assign pop   = ~empty & ready_i & ~flush_i;

    always_comb begin
        valid_o = rst_ni & ~flush_i & (~empty | bypass);
        data_o  = '0;
`ifdef ARA_MASK_ROUTER_BYPASS_EN
        if (valid_o) data_o = bypass ? data_i : mem_q[rd_ptr_q];
`else
        if (valid_o) data_o = mem_q[rd_ptr_q];
`endif
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (store) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)   rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d = cnt_q + cnt_t'(store) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (store) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/vfu_mask_router.sv
// Routes tagged mask beats to the FU whose active instruction ID matches.
// ARA_MASK_ROUTER_BYPASS_EN enables same-cycle delivery into an empty, ready FU queue.
module vfu_mask_router
    import ara_pkg::*;
    import vfu_mask_router_pkg::*;
#(
    parameter int unsigned NrFUs      = 2,
    parameter int unsigned QueueDepth = MaskRouterQueueDepth,
    parameter int unsigned DataWidth  = $bits(elen_t)
) (
    input logic               clk_i,
    input logic               rst_ni,
    vfu_mask_router_if.slave  bus
);

    localparam int unsigned StrbW = DataWidth / 8;

    logic [MaxFUs-1:0]           match;
    route_t                      rt;
    logic [NrFUs-1:0]            full;
    logic [NrFUs-1:0]            push;
    logic [NrFUs-1:0]            q_valid;
    logic [NrFUs-1:0][StrbW-1:0] q_data;
    logic                        target_free;
    logic                        ready;
    logic                        accept;
    logic                        conflict_q;

    always_comb begin
        match = '0;
        for (int i = 0; i < int'(NrFUs); i++) begin
            match[i] = bus.fu_vid_valid_i[i] && (bus.fu_vid_i[i] == bus.mask_vid_i);
        end
    end

    assign rt = route_lookup(match);

    // A full target still accepts when it is being flushed; the beat is dropped there.
    always_comb begin
        target_free = 1'b0;
        for (int i = 0; i < int'(NrFUs); i++) begin
            if (rt.idx == 3'(i)) target_free = ~full[i] | bus.fu_flush_i[i];
        end
    end

    assign ready  = rst_ni & rt.hit & target_free;
    assign accept = bus.mask_valid_i & ready;

    always_comb begin
        push = '0;
        for (int i = 0; i < int'(NrFUs); i++) begin
            push[i] = accept && (rt.idx == 3'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) conflict_q <= 1'b0;
        else         conflict_q <= accept & rt.multi;
    end

    for (genvar g = 0; g < int'(NrFUs); g++) begin : gen_queue
        vfu_mask_queue #(
            .Depth (QueueDepth),
            .Width (StrbW)
        ) u_queue (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (push[g]),
            .data_i  (bus.mask_i),
            .flush_i (bus.fu_flush_i[g]),
            .full_o  (full[g]),
            .valid_o (q_valid[g]),
            .data_o  (q_data[g]),
            .ready_i (bus.fu_mask_ready_i[g])
        );
    end

    assign bus.mask_ready_o    = ready;
    assign bus.fu_mask_valid_o = q_valid;
    assign bus.fu_mask_o       = q_data;
    assign bus.conflict_o      = rst_ni & conflict_q;

endmodule

// File: tb/tb_vfu_mask_router.sv
// Self-checking bench for vfu_mask_router: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_vfu_mask_router;
    import ara_pkg::*;

    localparam int unsigned NrFUs      = 2;
    localparam int unsigned QueueDepth = 2;
    localparam int unsigned DataWidth  = 64;
`ifdef ARA_MASK_ROUTER_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vfu_mask_router_if #(.NrFUs(NrFUs), .DataWidth(DataWidth)) bus ();

    vfu_mask_router #(
        .NrFUs      (NrFUs),
        .QueueDepth (QueueDepth),
        .DataWidth  (DataWidth)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: one queue of pending beats per FU plus the registered conflict flag.
    logic [7:0]             model_q [NrFUs][$];
    logic                   model_conf = 1'b0;
    int                     exp_tgt;
    logic                   exp_multi, exp_ready, exp_accept, exp_conf;
    logic [NrFUs-1:0]       exp_valid, exp_byp;
    logic [NrFUs-1:0][7:0]  exp_mask;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mask_i          = '0;
        bus.mask_vid_i      = '0;
        bus.mask_valid_i    = 1'b0;
        bus.fu_vid_i        = '0;
        bus.fu_vid_valid_i  = '0;
        bus.fu_mask_ready_i = '0;
        bus.fu_flush_i      = '0;
    endtask

    task automatic model_predict();
        int nm = 0;
        exp_tgt = -1;
        for (int i = 0; i < int'(NrFUs); i++) begin
            if (bus.fu_vid_valid_i[i] && bus.fu_vid_i[i] == bus.mask_vid_i) begin
                if (exp_tgt < 0) exp_tgt = i;
                nm++;
            end
        end
        exp_multi  = (nm >= 2);
        exp_ready  = rst_n && (exp_tgt >= 0) &&
                     (model_q[exp_tgt].size() < int'(QueueDepth) || bus.fu_flush_i[exp_tgt]);
        exp_accept = exp_ready && bus.mask_valid_i;
        for (int i = 0; i < int'(NrFUs); i++) begin
            exp_byp[i]   = Bypass && exp_accept && exp_tgt == i && model_q[i].size() == 0 &&
                           bus.fu_mask_ready_i[i] && !bus.fu_flush_i[i];
            exp_valid[i] = rst_n && !bus.fu_flush_i[i] && (model_q[i].size() > 0 || exp_byp[i]);
            exp_mask[i]  = !exp_valid[i] ? 8'h00 :
                           (model_q[i].size() > 0 ? model_q[i][0] : bus.mask_i);
        end
        exp_conf = rst_n && model_conf;
    endtask

    task automatic model_commit();
        if (!rst_n) begin
            for (int i = 0; i < int'(NrFUs); i++) model_q[i].delete();
            model_conf = 1'b0;
            return;
        end
        for (int i = 0; i < int'(NrFUs); i++) begin
            if (bus.fu_flush_i[i]) begin
                model_q[i].delete();
            end else begin
                if (model_q[i].size() > 0 && bus.fu_mask_ready_i[i]) void'(model_q[i].pop_front());
                if (exp_accept && exp_tgt == i && !exp_byp[i]) model_q[i].push_back(bus.mask_i);
            end
        end
        model_conf = exp_accept && exp_multi;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        bus.fu_vid_i[0]       = vid_t'(3);
        bus.fu_vid_valid_i[0] = 1'b1;
        bus.mask_vid_i        = vid_t'(3);
        bus.mask_valid_i      = 1'b1;
        bus.mask_i            = 8'h11;
        #1;
        tests_run++;
        if (bus.mask_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready_during: got %b want 0", bus.mask_ready_o);
        end
        tick();
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (bus.mask_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready_after: got %b want 1", bus.mask_ready_o);
        end
        tick();
        bus.mask_i = 8'h22;
        tick();
        bus.mask_valid_i = 1'b0;
        #1;
        tests_run++;
        if (bus.fu_mask_valid_o !== 2'b01 || bus.fu_mask_o[0] !== 8'h11) begin
            tests_failed++;
            $display("FAIL reset_prefill: valid %b mask %h want 01 11",
                     bus.fu_mask_valid_o, bus.fu_mask_o[0]);
        end
        rst_n = 1'b0;
        bus.mask_valid_i = 1'b1;
        tick();
        tests_run++;
        if (bus.fu_mask_valid_o !== 2'b00 || bus.mask_ready_o !== 1'b0 ||
            bus.conflict_o !== 1'b0 || bus.fu_mask_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid %b ready %b conf %b mask %h want all 0",
                     bus.fu_mask_valid_o, bus.mask_ready_o, bus.conflict_o, bus.fu_mask_o);
        end
        bus.mask_valid_i = 1'b0;
        rst_n = 1'b1;
        bus.fu_mask_ready_i = 2'b11;
        for (int c = 0; c < 2; c++) begin
            tick();
            tests_run++;
            if (bus.fu_mask_valid_o !== 2'b00) begin
                tests_failed++;
                $display("FAIL reset_no_delivery: valid %b want 00", bus.fu_mask_valid_o);
            end
        end
    endtask

    task automatic test_routing();
        idle();
        bus.fu_vid_i[0] = vid_t'(3);
        bus.fu_vid_i[1] = vid_t'(5);
        bus.fu_vid_valid_i  = 2'b11;
        bus.fu_mask_ready_i = 2'b11;
        bus.mask_vid_i   = vid_t'(5);
        bus.mask_i       = 8'hA5;
        bus.mask_valid_i = 1'b1;
        #1;
        tests_run++;
        if (bus.mask_ready_o !== 1'b1 || bus.fu_mask_valid_o !== {Bypass, 1'b0}) begin
            tests_failed++;
            $display("FAIL route_same_cycle: ready %b valid %b want 1 %b",
                     bus.mask_ready_o, bus.fu_mask_valid_o, {Bypass, 1'b0});
        end
        tick();
        bus.mask_valid_i = 1'b0;
        #1;
        tests_run++;
        if (bus.fu_mask_valid_o !== {!Bypass, 1'b0} ||
            bus.fu_mask_o[1] !== (Bypass ? 8'h00 : 8'hA5) || bus.fu_mask_o[0] !== 8'h00) begin
            tests_failed++;
            $display("FAIL route_fu1: valid %b mask %h want %b %h", bus.fu_mask_valid_o,
                     bus.fu_mask_o, {!Bypass, 1'b0}, Bypass ? 8'h00 : 8'hA5);
        end
        tick();
        tests_run++;
        if (bus.fu_mask_valid_o !== 2'b00) begin
            tests_failed++;
            $display("FAIL route_drained: valid %b want 00", bus.fu_mask_valid_o);
        end
    endtask

    task automatic test_backpressure();
        idle();
        bus.fu_vid_i[0]       = vid_t'(3);
        bus.fu_vid_valid_i[0] = 1'b1;
        bus.mask_vid_i        = vid_t'(3);
        bus.mask_valid_i      = 1'b1;
        bus.mask_i            = 8'h01;
        tick();
        bus.mask_i = 8'h02;
        tick();
        bus.mask_i = 8'h03;
        #1;
        tests_run++;
        if (bus.mask_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_third_stall: ready %b want 0", bus.mask_ready_o);
        end
        tick();
        tests_run++;
        if (bus.mask_ready_o !== 1'b0 || bus.fu_mask_o[0] !== 8'h01) begin
            tests_failed++;
            $display("FAIL bp_hold: ready %b head %h want 0 01", bus.mask_ready_o, bus.fu_mask_o[0]);
        end
        bus.fu_mask_ready_i[0] = 1'b1;
        #1;
        tests_run++;
        if (bus.mask_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_full_with_pop: ready %b want 0", bus.mask_ready_o);
        end
        tick();
        tests_run++;
        if (bus.mask_ready_o !== 1'b1 || bus.fu_mask_o[0] !== 8'h02) begin
            tests_failed++;
            $display("FAIL bp_after_pop: ready %b head %h want 1 02", bus.mask_ready_o, bus.fu_mask_o[0]);
        end
        tick();
        bus.mask_valid_i = 1'b0;
        #1;
        tests_run++;
        if (bus.fu_mask_valid_o[0] !== 1'b1 || bus.fu_mask_o[0] !== 8'h03) begin
            tests_failed++;
            $display("FAIL bp_push_pop: valid %b head %h want 1 03",
                     bus.fu_mask_valid_o[0], bus.fu_mask_o[0]);
        end
        tick();
        tests_run++;
        if (bus.fu_mask_valid_o !== 2'b00) begin
            tests_failed++;
            $display("FAIL bp_empty: valid %b want 00", bus.fu_mask_valid_o);
        end
    endtask

    task automatic test_conflict();
        idle();
        bus.fu_vid_i[0] = vid_t'(4);
        bus.fu_vid_i[1] = vid_t'(4);
        bus.fu_vid_valid_i = 2'b11;
        bus.mask_vid_i     = vid_t'(4);
        bus.mask_i         = 8'h5A;
        bus.mask_valid_i   = 1'b1;
        #1;
        tests_run++;
        if (bus.conflict_o !== 1'b0 || bus.mask_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL conf_before: conf %b ready %b want 0 1", bus.conflict_o, bus.mask_ready_o);
        end
        tick();
        bus.mask_valid_i = 1'b0;
        #1;
        tests_run++;
        if (bus.conflict_o !== 1'b1 || bus.fu_mask_valid_o !== 2'b01 || bus.fu_mask_o[0] !== 8'h5A) begin
            tests_failed++;
            $display("FAIL conf_pulse: conf %b valid %b head %h want 1 01 5a",
                     bus.conflict_o, bus.fu_mask_valid_o, bus.fu_mask_o[0]);
        end
        tick();
        tests_run++;
        if (bus.conflict_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL conf_one_cycle: conf %b want 0", bus.conflict_o);
        end
        bus.fu_flush_i = 2'b01;
        tick();
        bus.fu_flush_i = 2'b00;
    endtask

    task automatic test_flush();
        idle();
        bus.fu_vid_i[1]       = vid_t'(6);
        bus.fu_vid_valid_i[1] = 1'b1;
        bus.mask_vid_i        = vid_t'(6);
        bus.mask_valid_i      = 1'b1;
        bus.mask_i            = 8'hC1;
        tick();
        bus.mask_i = 8'hC2;
        tick();
        bus.mask_i = 8'hC3;
        bus.fu_flush_i[1] = 1'b1;
        #1;
        tests_run++;
        if (bus.fu_mask_valid_o[1] !== 1'b0 || bus.mask_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_cycle: valid %b ready %b want 0 1",
                     bus.fu_mask_valid_o[1], bus.mask_ready_o);
        end
        tick();
        bus.fu_flush_i      = 2'b00;
        bus.mask_valid_i    = 1'b0;
        bus.fu_mask_ready_i = 2'b11;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests_run++;
            if (bus.fu_mask_valid_o !== 2'b00) begin
                tests_failed++;
                $display("FAIL flush_empty: valid %b want 00", bus.fu_mask_valid_o);
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        idle();
        bus.fu_vid_i[0]       = vid_t'(3);
        bus.fu_vid_valid_i[0] = 1'b1;
        bus.fu_mask_ready_i   = 2'b11;
        bus.mask_vid_i        = vid_t'(3);
        bus.mask_i            = 8'h0F;
        bus.mask_valid_i      = 1'b1;
        #1;
        tests_run++;
        if (bus.fu_mask_valid_o[0] !== Bypass || bus.fu_mask_o[0] !== (Bypass ? 8'h0F : 8'h00)) begin
            tests_failed++;
            $display("FAIL bypass_same_cycle: valid %b mask %h want %b %h", bus.fu_mask_valid_o[0],
                     bus.fu_mask_o[0], Bypass, Bypass ? 8'h0F : 8'h00);
        end
        tick();
        bus.mask_valid_i = 1'b0;
        #1;
        tests_run++;
        if (bus.fu_mask_valid_o[0] !== !Bypass || bus.fu_mask_o[0] !== (Bypass ? 8'h00 : 8'h0F)) begin
            tests_failed++;
            $display("FAIL bypass_next_cycle: valid %b mask %h want %b %h", bus.fu_mask_valid_o[0],
                     bus.fu_mask_o[0], !Bypass, Bypass ? 8'h00 : 8'h0F);
        end
        tick();
    endtask

    task automatic test_random();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < int'(NrFUs); i++) model_q[i].delete();
        model_conf = 1'b0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < int'(NrFUs); i++) begin
                bus.fu_vid_i[i]        = vid_t'($urandom_range(3));
                bus.fu_vid_valid_i[i]  = ($urandom_range(3) != 0);
                bus.fu_mask_ready_i[i] = ($urandom_range(1) != 0);
                bus.fu_flush_i[i]      = ($urandom_range(15) == 0);
            end
            bus.mask_vid_i   = vid_t'($urandom_range(3));
            bus.mask_valid_i = ($urandom_range(3) != 0);
            bus.mask_i       = 8'($urandom);
            rst_n            = ($urandom_range(63) != 0);
            #1;
            model_predict();
            tests_run++;
            if (bus.mask_ready_o !== exp_ready || bus.fu_mask_valid_o !== exp_valid ||
                bus.fu_mask_o !== exp_mask || bus.conflict_o !== exp_conf) begin
                tests_failed++;
                $display("FAIL random_cycle_%0d: ready %b valid %b mask %h conf %b want %b %b %h %b",
                         c, bus.mask_ready_o, bus.fu_mask_valid_o, bus.fu_mask_o, bus.conflict_o,
                         exp_ready, exp_valid, exp_mask, exp_conf);
            end
            model_commit();
            tick();
        end
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        test_reset();
        test_routing();
        test_backpressure();
        test_conflict();
        test_flush();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vfu_mask_router.md
VFU_MASK_ROUTER -- requirements
Module: vfu_mask_router

Interface
REQ-001 SHALL have parameter NrFUs, default 2: number of mask-consuming functional units, 1..8.
REQ-002 SHALL have parameter QueueDepth, default 2: per-FU mask FIFO depth, power of two, 1..8.
REQ-003 SHALL have parameter DataWidth, default $bits(elen_t); strb_t = logic [DataWidth/8-1:0].
REQ-004 SHALL have clk_i  input  1  clock; one clock, all state on its rising edge.
REQ-005 SHALL have rst_ni  input  1  reset; synchronous, active-low.
REQ-006 SHALL have mask_i  input  strb_t  mask beat from mask unit.
REQ-007 SHALL have mask_vid_i  input  vid_t  instruction ID tag of mask beat.
REQ-008 SHALL have mask_valid_i / mask_ready_o  input / output  1  mask-beat handshake.
REQ-009 SHALL have fu_vid_i  input  [NrFUs] vid_t  ID of each FU's current masked instruction.
REQ-010 SHALL have fu_vid_valid_i  input  [NrFUs]  FU has an active masked instruction.
REQ-011 SHALL have fu_mask_o  output  [NrFUs] strb_t  routed mask per FU.
REQ-012 SHALL have fu_mask_valid_o / fu_mask_ready_i  output / input  [NrFUs]  per-FU handshake.
REQ-013 SHALL have fu_flush_i  input  [NrFUs]  discard FU's queued beats.
REQ-014 SHALL have conflict_o  output  1  one-cycle pulse: beat tag matched >1 FU.

Function
REQ-015 Target FU SHALL be lowest index i with fu_vid_valid_i[i] and fu_vid_i[i]==mask_vid_i.
REQ-016 mask_ready_o SHALL be 1 iff a target exists and its FIFO is not full; no match -> beat stalls (never dropped).
REQ-017 Full FIFO SHALL deassert mask_ready_o even when a pop occurs the same cycle.
REQ-018 Accepted beat SHALL be pushed only into target FU's FIFO; other FIFOs unchanged.
REQ-019 fu_mask_valid_o[i] SHALL equal FIFO i non-empty; fu_mask_o[i] SHALL be its head; pop on valid&ready.
REQ-020 Simultaneous push and pop on same non-full FIFO SHALL both occur; occupancy unchanged.
REQ-021 Read/write pointers SHALL wrap modulo QueueDepth; occupancy counter width $clog2(QueueDepth+1).
REQ-022 fu_flush_i[i] SHALL empty FIFO i next cycle; fu_mask_valid_o[i] held 0 during flush cycle.
REQ-023 Push to FU i coincident with fu_flush_i[i] SHALL be consumed (ready=1) and discarded.
REQ-024 conflict_o SHALL pulse for one cycle when an accepted beat matched >=2 FUs.
REQ-025 Without bypass (REQ-030), push-to-fu_mask_valid_o latency SHALL be exactly 1 cycle.
REQ-026 Beat order per FU SHALL be preserved.

Reset
REQ-027 rst_ni low at clock edge SHALL empty all FIFOs, zero pointers/counters, clear conflict_o.
REQ-028 During/after reset mask_ready_o, fu_mask_valid_o, conflict_o SHALL be 0; fu_mask_o SHALL be 0.
REQ-029 Reset mid-transfer SHALL discard all queued beats without delivering them.

Configuration
REQ-030 Macro ARA_MASK_ROUTER_BYPASS_EN defined: target FIFO empty and fu_mask_ready_i high -> beat SHALL appear on fu_mask_o same cycle and not be stored.
REQ-031 Macro undefined: no combinational path mask_valid_i/mask_i -> fu_mask_valid_o/fu_mask_o.

Structure
REQ-032 vid_t and NrVInsn SHALL come from ara_pkg; localparam MaskRouterQueueDepth SHALL be added to ara_pkg.
REQ-033 One sub-module vfu_mask_queue (single FIFO with flush, optional bypass) SHALL be instantiated NrFUs times.

Verification
REQ-034 Reset: rst_ni=0 with FIFO0 holding 2 beats -> next cycle fu_mask_valid_o=0, mask_ready_o=0.
REQ-035 Routing: NrFUs=2, fu_vid={3,5} valid, send vid=5 mask=8'hA5 -> fu_mask_o[1]=8'hA5 after 1 cycle, FU0 idle.
REQ-036 Backpressure: QueueDepth=2, fu_mask_ready_i[0]=0, three vid=3 beats -> third stalls until one pop.
REQ-037 Conflict: fu_vid={4,4} valid, vid=4 beat -> FU0 receives, conflict_o=1 one cycle.
REQ-038 Flush: FIFO1 holds 2 beats, fu_flush_i[1]=1 with push to FU1 -> FIFO1 empty, nothing delivered.
REQ-039 Bypass build: FIFO0 empty, ready=1, vid=3 mask=8'h0F -> fu_mask_o[0]=8'h0F same cycle.
